// File: rtl/gesture_axil_pkg.sv
// gesture_axil_pkg: shared response codes, FSM state types and byte-merge helper for the register slave
package gesture_axil_pkg;

    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // Merge the strobed bytes of data into old, leaving unstrobed bytes untouched
    function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
        input logic [AXIL_DATA_W-1:0]   old,
        input logic [AXIL_DATA_W-1:0]   data,
        input logic [AXIL_DATA_W/8-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] r;
        for (int b = 0; b < AXIL_DATA_W/8; b++)
            r[8*b+:8] = strb[b] ? data[8*b+:8] : old[8*b+:8];
        return r;
    endfunction

endpackage

// File: rtl/gesture_axil_regs.sv
// gesture_axil_regs: AXI4-Lite slave holding NUM_REGS 32-bit control registers for the gesture pipeline
module gesture_axil_regs
    import gesture_axil_pkg::*;
#(
    parameter int          ADDR_W    = 5,
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int              IW    = ADDR_W - 2;
    localparam logic [IW:0]     NREGS = (IW+1)'(NUM_REGS);

    logic [31:0]  regs [NUM_REGS];
    wr_state_t    wr_state, wr_next;
    rd_state_t    rd_state, rd_next;
    logic         aw_got, w_got, aw_got_n, w_got_n;
    logic         aw_hs, w_hs, ar_hs;
    logic [IW-1:0] widx, ridx;
    logic [31:0]  wdata_q, rd_word;
    logic [3:0]   wstrb_q;
    logic         w_hit, r_hit;
    logic         unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ridx  = S_AXI_ARADDR[ADDR_W-1:2];
    assign w_hit = {1'b0, widx} < NREGS;
    assign r_hit = {1'b0, ridx} < NREGS;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[32*g+:32] = regs[g];
    end

    // Write FSM next state; AW and W are tracked separately until both have arrived
    always_comb begin
        wr_next  = wr_state;
        aw_got_n = 1'b0;
        w_got_n  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                aw_got_n = aw_got || aw_hs;
                w_got_n  = w_got || w_hs;
                if (aw_got_n && w_got_n) begin
                    wr_next  = WR_EXEC;
                    aw_got_n = 1'b0;
                    w_got_n  = 1'b0;
                end
            end
            WR_EXEC: wr_next = WR_RESP;
            WR_RESP: wr_next = S_AXI_BREADY ? WR_IDLE : WR_RESP;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Read FSM next state: one outstanding read, released by the R handshake
    always_comb begin
        rd_next = (rd_state == RD_IDLE) ? (ar_hs ? RD_RESP : RD_IDLE)
                                        : (S_AXI_RREADY ? RD_IDLE : RD_RESP);
    end

    // Write strobe to the pipeline is high for exactly the WR_EXEC cycle of an in-range write
    always_comb begin
        reg_wr_pulse = '0;
        for (int i = 0; i < NUM_REGS; i++)
            reg_wr_pulse[i] = (wr_state == WR_EXEC) && (widx == IW'(i));
    end

    // Read mux over the register file; out-of-range indices never match and read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ridx == IW'(i))
                rd_word = regs[i];
    end

    // State registers for both channel FSMs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // Write channel datapath: capture AW/W, merge into the register file, drive B
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            widx          <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VAL;
        end else begin
            aw_got        <= aw_got_n;
            w_got         <= w_got_n;
            S_AXI_AWREADY <= (wr_next == WR_IDLE) && !aw_got_n;
            S_AXI_WREADY  <= (wr_next == WR_IDLE) && !w_got_n;
            if (aw_hs)
                widx <= S_AXI_AWADDR[ADDR_W-1:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_state == WR_EXEC) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= w_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++)
                    if (widx == IW'(i))
                        regs[i] <= apply_wstrb(regs[i], wdata_q, wstrb_q);
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read channel datapath: sample the register on the AR handshake and hold until R handshakes
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S_AXI_ARREADY <= (rd_next == RD_IDLE);
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= r_hit ? rd_word : 32'h0;
                S_AXI_RRESP  <= r_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gesture_axil_regs.sv
// tb_gesture_axil_regs: scoreboard bench for the AXI4-Lite register slave
module tb_gesture_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] reg_q;
    logic [3:0]  reg_wr_pulse;

    int          total = 0;
    int          bad = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] exp_regs [4];
    int          exp_pulse [4];
    int          pulse_cnt [4];

    gesture_axil_regs dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor: pop the scoreboard on every B/R handshake and count write pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) check("b_unexpected", bq.size(), 1);
                else check("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_unexpected", rq.size(), 1);
                else check("rresp_rdata", {rresp, rdata}, rq.pop_front());
            end
            for (int i = 0; i < 4; i++)
                if (reg_wr_pulse[i]) pulse_cnt[i]++;
        end
    end

    task automatic wr_issue(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        logic aw_go, w_go;
        int n;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (a[4:2] < 3'd4) begin
            exp_regs[a[3:2]] = (exp_regs[a[3:2]] & ~m) | (d & m);
            exp_pulse[a[3:2]]++;
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go = wvalid && wready;
            @(posedge clk); #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            n++;
        end
        check("wr_hs_timeout", {awvalid, wvalid}, 0);
    endtask

    task automatic rd_issue(input logic [4:0] a);
        logic ar_go;
        int n;
        if (a[4:2] < 3'd4) rq.push_back({2'b00, exp_regs[a[3:2]]});
        else rq.push_back({2'b10, 32'h0});
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 50) begin
            @(negedge clk);
            ar_go = arvalid && arready;
            @(posedge clk); #1;
            if (ar_go) arvalid = 1'b0;
            n++;
        end
        check("rd_hs_timeout", arvalid, 0);
    endtask

    task automatic wait_b();
        int n = 0;
        while (bq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("b_wait", bq.size(), 0);
    endtask

    task automatic wait_r();
        int n = 0;
        while (rq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("r_wait", rq.size(), 0);
    endtask

    task automatic wait_valid(input logic is_b);
        int n = 0;
        while (!(is_b ? bvalid : rvalid) && n < 50) begin @(negedge clk); n++; end
        check(is_b ? "bvalid_wait" : "rvalid_wait", is_b ? bvalid : rvalid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        for (int i = 0; i < 4; i++) begin exp_regs[i] = 32'h0; exp_pulse[i] = 0; pulse_cnt[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_ready", {awready, wready, arready}, 0);
        check("rst_valid", {bvalid, rvalid}, 0);
        check("rst_payload", {bresp, rresp, rdata}, 0);
        check("rst_reg_q", reg_q[63:0] | reg_q[127:64], 0);
        check("rst_pulse", reg_wr_pulse, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 4; i++) begin
            wr_issue(5'(4*i), 32'(i + 1), 4'hF);
            wait_b();
        end
        for (int i = 0; i < 4; i++) begin
            rd_issue(5'(4*i));
            wait_r();
        end
        for (int i = 0; i < 4; i++) check("pulse_once", pulse_cnt[i], 1);

        // W three cycles ahead of AW, then B latency from the AW handshake
        bq.push_back(2'b00); exp_regs[2] = 32'hDEADBEEF; exp_pulse[2]++;
        @(posedge clk); #1 wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); check("w_first_ready", wready, 1);
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_b_before_aw", {bvalid, awready, wready}, 3'b010);
        end
        @(posedge clk); #1 awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk); check("aw_late_ready", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk); check("b_lat_edge1", bvalid, 0);
        @(negedge clk); check("b_lat_edge2", bvalid, 1);
        check("reg2_deadbeef", reg_q[95:64], 32'hDEADBEEF);
        wait_b();

        // Byte-strobe merge and zero-strobe write
        wr_issue(5'h04, 32'h11223344, 4'hF); wait_b();
        wr_issue(5'h04, 32'hAABBCCDD, 4'b0101); wait_b();
        check("strb_merge", reg_q[63:32], 32'h11BB33DD);
        rd_issue(5'h04); wait_r();
        wr_issue(5'h04, 32'hFFFFFFFF, 4'b0000); wait_b();
        check("strb_zero", reg_q[63:32], 32'h11BB33DD);
        rd_issue(5'h05); wait_r();

        // Out-of-range write and read
        wr_issue(5'h10, 32'h12345678, 4'hF); wait_b();
        rd_issue(5'h1C); wait_r();
        check("oor_no_change", reg_q, {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]});

        // Backpressure on B
        bready = 1'b0;
        wr_issue(5'h0C, 32'hCAFE0001, 4'hF);
        wait_valid(1'b1);
        repeat (10) begin
            @(negedge clk);
            check("b_stall", {bvalid, bresp, awready, wready}, 5'b10000);
        end
        @(posedge clk); #1 bready = 1'b1;
        wait_b();

        // Backpressure on R
        rready = 1'b0;
        rd_issue(5'h0C);
        wait_valid(1'b0);
        hold = rdata;
        repeat (10) begin
            @(negedge clk);
            check("r_stall", {rvalid, rresp, rdata, arready}, {1'b1, 2'b00, hold, 1'b0});
        end
        check("r_stall_data", hold, 32'hCAFE0001);
        @(posedge clk); #1 rready = 1'b1;
        wait_r();

        // Reset while a write response is pending
        bready = 1'b0;
        wr_issue(5'h00, 32'h5, 4'hF);
        wait_valid(1'b1);
        check("reg0_before_rst", reg_q[31:0], 32'h5);
        #3 rst = 1'b1;
        #1;
        check("rst_async_bvalid", bvalid, 0);
        check("rst_async_reg0", reg_q[31:0], 32'h0);
        bq.delete();
        for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
        bready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_b", bvalid, 0);
        end
        rd_issue(5'h00); wait_r();

        for (int i = 0; i < 4; i++) check("pulse_total", pulse_cnt[i], exp_pulse[i]);
        check("final_reg_q", reg_q, {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
